// File: rtl/seg_demux_pkg.sv
// Shared definitions for the segment bus demultiplexer and the display driver:
// strobe/segment bit positions, frame classification, FSM states, hex table.
package seg_demux_pkg;

  localparam int HI_STROBE_BIT = 7;
  localparam int LO_STROBE_BIT = 5;
  localparam logic [11:0] RESERVED_MASK = 12'hC00;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 6;
  localparam int SEG_G  = 8;
  localparam int SEG_DP = 9;

  localparam int LOW_FRAMES_MAX = 15;

  typedef logic [1:0] state_t;
  localparam state_t ST_SYNC      = 2'd0;
  localparam state_t ST_WANT_LOW  = 2'd1;
  localparam state_t ST_WANT_HIGH = 2'd2;

  typedef enum logic [1:0] {
    FRAME_ILLEGAL = 2'd0,
    FRAME_HIGH    = 2'd1,
    FRAME_LOW     = 2'd2
  } frame_kind_t;

  // Hex digit to {g,f,e,d,c,b,a}, active high.
  function automatic logic [6:0] hex_seg(input logic [3:0] n);
    case (n)
      4'h0: hex_seg = 7'h3F;
      4'h1: hex_seg = 7'h06;
      4'h2: hex_seg = 7'h5B;
      4'h3: hex_seg = 7'h4F;
      4'h4: hex_seg = 7'h66;
      4'h5: hex_seg = 7'h6D;
      4'h6: hex_seg = 7'h7D;
      4'h7: hex_seg = 7'h07;
      4'h8: hex_seg = 7'h7F;
      4'h9: hex_seg = 7'h6F;
      4'hA: hex_seg = 7'h77;
      4'hB: hex_seg = 7'h7C;
      4'hC: hex_seg = 7'h39;
      4'hD: hex_seg = 7'h5E;
      4'hE: hex_seg = 7'h79;
      default: hex_seg = 7'h71;
    endcase
  endfunction

  function automatic logic [7:0] extract_seg(input logic [11:0] bus);
    extract_seg = {bus[SEG_DP], bus[SEG_G], bus[SEG_F], bus[SEG_E],
                   bus[SEG_D], bus[SEG_C], bus[SEG_B], bus[SEG_A]};
  endfunction

  function automatic frame_kind_t classify(input logic [11:0] bus);
    if ((bus & RESERVED_MASK) != 12'h000)
      classify = FRAME_ILLEGAL;
    else if (bus[HI_STROBE_BIT] && !bus[LO_STROBE_BIT])
      classify = FRAME_HIGH;
    else if (bus[LO_STROBE_BIT] && !bus[HI_STROBE_BIT])
      classify = FRAME_LOW;
    else
      classify = FRAME_ILLEGAL;
  endfunction

endpackage

// File: rtl/seg_demux_seg7_decode.sv
// Combinational reverse lookup of a 7-segment pattern into its hex nibble;
// hit is low when the pattern matches no table entry.
module seg7_decode
  import seg_demux_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       hit
);

  always_comb begin
    nibble = 4'h0;
    hit    = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (hex_seg(4'(i)) == pattern) begin
        nibble = 4'(i);
        hit    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg_demux.sv
// Demultiplexes a strobed two-digit 7-segment bus into digit patterns, a byte
// and lock/error status. Define SEG_DEMUX_DECODE_EN to enable hex decoding.
module seg_demux
  import seg_demux_pkg::*;
#(
  parameter int LOCK_FRAMES = 2,
  parameter int ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [11:0]      seg_bus,
  output logic [7:0]       low_seg,
  output logic [7:0]       high_seg,
  output logic [7:0]       byte_out,
  output logic             pair_valid,
  output logic             locked,
  output logic             frame_err,
  output logic [ERR_W-1:0] err_cnt
);

  logic [11:0]      in_q;
  state_t           state_reg, state_next;
  logic [3:0]       alt_cnt_reg, alt_cnt_next;
  logic             pend_reg, pend_next;
  logic [7:0]       low_seg_reg, low_seg_next;
  logic [7:0]       high_seg_reg, high_seg_next;
  logic [7:0]       byte_reg, byte_next;
  logic             pv_reg, pv_next;
  logic             fe_reg, fe_next;
  logic             locked_reg, locked_next;
  logic [ERR_W-1:0] err_cnt_reg, err_cnt_next;

  frame_kind_t      kind;
  logic [7:0]       frame_seg;
  logic             alt_err;
  logic             alt_inc;
  logic             pair_ok;
  logic [7:0]       pair_byte;

  // Decoder 0 sees the held high digit, decoder 1 the incoming low frame.
  logic [6:0]       dec_pat [2];
  logic [3:0]       dec_nib [2];
  logic             dec_hit [2];

  assign kind       = classify(in_q);
  assign frame_seg  = extract_seg(in_q);
  assign dec_pat[0] = high_seg_reg[6:0];
  assign dec_pat[1] = frame_seg[6:0];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dec
      seg7_decode u_dec (
        .pattern (dec_pat[gi]),
        .nibble  (dec_nib[gi]),
        .hit     (dec_hit[gi])
      );
    end
  endgenerate

`ifdef SEG_DEMUX_DECODE_EN
  assign pair_ok   = dec_hit[0] & dec_hit[1];
  assign pair_byte = {dec_nib[0], dec_nib[1]};
`else
  // Decoder results are not consumed in this build and fold away.
  logic unused_dec;
  assign unused_dec = ^{dec_nib[0], dec_nib[1], dec_hit[0], dec_hit[1]};
  assign pair_ok    = 1'b1;
  assign pair_byte  = 8'h00;
`endif

  always_comb begin
    state_next    = state_reg;
    alt_cnt_next  = alt_cnt_reg;
    pend_next     = pend_reg;
    low_seg_next  = low_seg_reg;
    high_seg_next = high_seg_reg;
    byte_next     = byte_reg;
    pv_next       = 1'b0;
    fe_next       = 1'b0;
    alt_err       = 1'b0;
    alt_inc       = 1'b0;

    case (kind)
      FRAME_HIGH: begin
        high_seg_next = frame_seg;
        pend_next     = 1'b1;
        if (state_reg == ST_WANT_LOW) begin
          alt_err = 1'b1;
        end else begin
          alt_inc    = (state_reg == ST_WANT_HIGH);
          state_next = ST_WANT_LOW;
        end
      end
      FRAME_LOW: begin
        low_seg_next = frame_seg;
        if (state_reg == ST_WANT_HIGH) begin
          alt_err = 1'b1;
        end else begin
          if (state_reg == ST_WANT_LOW) begin
            alt_inc = 1'b1;
            if (pend_reg) begin
              if (pair_ok) begin
                pv_next   = 1'b1;
                byte_next = pair_byte;
                pend_next = 1'b0;
              end else begin
                fe_next = 1'b1;
              end
            end
          end
          state_next = ST_WANT_HIGH;
        end
      end
      default: begin
        if (state_reg != ST_SYNC) begin
          alt_err    = 1'b1;
          state_next = ST_SYNC;
        end
      end
    endcase

    // Loss of alternation and an undecodable pair share a single error pulse.
    if (alt_err) begin
      fe_next      = 1'b1;
      alt_cnt_next = 4'd0;
    end else if (alt_inc && alt_cnt_reg != 4'(LOW_FRAMES_MAX)) begin
      alt_cnt_next = alt_cnt_reg + 4'd1;
    end

    locked_next  = (alt_cnt_next >= 4'(LOCK_FRAMES));
    err_cnt_next = err_cnt_reg;
    if (fe_next && err_cnt_reg != {ERR_W{1'b1}})
      err_cnt_next = err_cnt_reg + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_q         <= 12'h000;
      state_reg    <= ST_SYNC;
      alt_cnt_reg  <= 4'd0;
      pend_reg     <= 1'b0;
      low_seg_reg  <= 8'h00;
      high_seg_reg <= 8'h00;
      byte_reg     <= 8'h00;
      pv_reg       <= 1'b0;
      fe_reg       <= 1'b0;
      locked_reg   <= 1'b0;
      err_cnt_reg  <= '0;
    end else begin
      in_q         <= seg_bus;
      state_reg    <= state_next;
      alt_cnt_reg  <= alt_cnt_next;
      pend_reg     <= pend_next;
      low_seg_reg  <= low_seg_next;
      high_seg_reg <= high_seg_next;
      byte_reg     <= byte_next;
      pv_reg       <= pv_next;
      fe_reg       <= fe_next;
      locked_reg   <= locked_next;
      err_cnt_reg  <= err_cnt_next;
    end
  end

  assign low_seg    = low_seg_reg;
  assign high_seg   = high_seg_reg;
  assign byte_out   = byte_reg;
  assign pair_valid = pv_reg;
  assign locked     = locked_reg;
  assign frame_err  = fe_reg;
  assign err_cnt    = err_cnt_reg;

endmodule

// File: tb/tb_seg_demux.sv
// Directed and random stimulus for seg_demux, checked every cycle against a
// frame-level reference model of the bus protocol.
module tb_seg_demux;

  localparam int LOCK_FRAMES = 2;
  localparam int ERR_W       = 8;
  localparam int ERR_MAX     = (1 << ERR_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [11:0]      seg_bus = 12'h000;
  logic [7:0]       low_seg, high_seg, byte_out;
  logic             pair_valid, locked, frame_err;
  logic [ERR_W-1:0] err_cnt;

  seg_demux #(.LOCK_FRAMES(LOCK_FRAMES), .ERR_W(ERR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seg_bus    (seg_bus),
    .low_seg    (low_seg),
    .high_seg   (high_seg),
    .byte_out   (byte_out),
    .pair_valid (pair_valid),
    .locked     (locked),
    .frame_err  (frame_err),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference state: what the bus expects next (0 nothing, 1 low, 2 high).
  logic [11:0] m_prev;
  int          m_expect;
  int          m_alt;
  int          m_err;
  bit          m_pend;
  logic [7:0]  m_low, m_high, m_byte;
  bit          m_pv, m_fe;

  function automatic int nib_of(logic [6:0] p);
    for (int i = 0; i < 16; i++)
      if (hex_tab[i] == p) return i;
    return -1;
  endfunction

  // Build a bus word: strobe plus segments {dp,g,f,e,d,c,b,a} in their lanes.
  function automatic logic [11:0] frame(bit high, logic [7:0] p);
    logic [11:0] b;
    b = 12'h000;
    b[4:0] = p[4:0];
    b[6] = p[5];
    b[8] = p[6];
    b[9] = p[7];
    if (high) b[7] = 1'b1; else b[5] = 1'b1;
    return b;
  endfunction

  function automatic logic [11:0] digit(bit high, int d);
    return frame(high, {1'b0, hex_tab[d]});
  endfunction

  task automatic model_edge(bit r, logic [11:0] b);
    logic [11:0] f;
    logic [7:0]  pat;
    bit          hi, lo, bad;
    int          hn, ln;
    if (!r) begin
      m_prev = 12'h000; m_expect = 0; m_alt = 0; m_err = 0; m_pend = 0;
      m_low = 8'h00; m_high = 8'h00; m_byte = 8'h00; m_pv = 0; m_fe = 0;
      return;
    end
    f   = m_prev;
    pat = {f[9], f[8], f[6], f[4:0]};
    hi  = f[7] && !f[5] && f[11:10] == 2'b00;
    lo  = f[5] && !f[7] && f[11:10] == 2'b00;
    bad = 0; m_pv = 0; m_fe = 0;
    if (hi) begin
      if (m_expect == 1) bad = 1;
      else begin
        if (m_expect == 2 && m_alt < 15) m_alt++;
        m_expect = 1;
      end
      m_high = pat;
      m_pend = 1;
    end else if (lo) begin
      if (m_expect == 2) bad = 1;
      else begin
        if (m_expect == 1) begin
          if (m_alt < 15) m_alt++;
          if (m_pend) begin
`ifdef SEG_DEMUX_DECODE_EN
            hn = nib_of(m_high[6:0]);
            ln = nib_of(pat[6:0]);
            if (hn >= 0 && ln >= 0) begin
              m_pv = 1; m_byte = {hn[3:0], ln[3:0]}; m_pend = 0;
            end else m_fe = 1;
`else
            hn = 0; ln = 0;
            m_pv = 1; m_pend = 0;
`endif
          end
        end
        m_expect = 2;
      end
      m_low = pat;
    end else if (m_expect != 0) begin
      bad = 1;
      m_expect = 0;
    end
    if (bad) begin m_fe = 1; m_alt = 0; end
    if (m_fe && m_err < ERR_MAX) m_err++;
    m_prev = b;
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step(bit r, logic [11:0] b);
    rst_n   = r;
    seg_bus = b;
    @(posedge clk);
    model_edge(r, b);
    #1;
    check("low_seg",    32'(low_seg),    32'(m_low));
    check("high_seg",   32'(high_seg),   32'(m_high));
    check("byte_out",   32'(byte_out),   32'(m_byte));
    check("pair_valid", 32'(pair_valid), 32'(m_pv));
    check("frame_err",  32'(frame_err),  32'(m_fe));
    check("locked",     32'(locked),     32'(m_alt >= LOCK_FRAMES));
    check("err_cnt",    32'(err_cnt),    32'(m_err));
  endtask

  initial begin
    int r;
    // reset state
    step(0, 12'h000);
    step(0, 12'hFFF);
    // alternating HIGH(3)/LOW(7)
    for (int i = 0; i < 4; i++) begin
      step(1, digit(1, 3));
      step(1, digit(0, 7));
    end
    // two HIGHs while locked, then LOW(A)
    step(1, digit(1, 6));
    step(1, digit(1, 8));
    step(1, digit(0, 10));
    step(1, digit(1, 4));
    step(1, digit(0, 4));
    // both strobes while locked, then recover with HIGH(1), LOW(2)
    step(1, 12'h0A6);
    step(1, digit(1, 1));
    step(1, digit(0, 2));
    step(1, digit(1, 3));
    // undecodable LOW after HIGH(5), reserved bits set, dp on digits
    step(1, digit(1, 5));
    step(1, 12'h020);
    step(1, 12'h400 | digit(1, 2));
    step(1, frame(1, 8'h86));
    step(1, frame(0, 8'hBF));
    step(1, 12'h000);
    step(1, 12'h000);
    // saturate the error counter with repeated HIGH frames
    for (int i = 0; i < 310; i++) step(1, digit(1, i % 16));
    step(1, digit(0, 9));
    step(1, 12'h000);
    // reset between HIGH(9) and LOW(4)
    step(1, digit(1, 9));
    step(0, digit(1, 9));
    step(1, digit(0, 4));
    step(1, digit(1, 2));
    step(1, digit(0, 1));
    step(1, 12'h000);
    // random traffic
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 38)      step(1, digit(1, $urandom_range(0, 15)));
      else if (r < 76) step(1, digit(0, $urandom_range(0, 15)));
      else if (r < 86) step(1, frame($urandom_range(0, 1) == 1, 8'($urandom)));
      else if (r < 94) step(1, 12'($urandom));
      else if (r < 99) step(1, 12'h000);
      else             step(0, 12'($urandom));
    end
    step(1, 12'h000);
    step(1, 12'h000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
